posit_lzc_pipe: RTL and testbench

//  Parametrised, 2-stage pipelined leading-run counter for the posit decode path.

---
 rtl/posit_lzc_pkg.sv | 15 +
 rtl/lzc_nibble.sv | 22 ++
 rtl/posit_lzc_pipe.sv | 164 ++++++++++++++++
 tb/tb_posit_lzc_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_lzc_pkg.sv
// posit_lzc_pkg
// Shared definitions for the posit leading-run counter.
//   LZC_MODE_*  : encodings of the in_mode port (2'b11 is decoded as LZ)
//   lzc_cw()    : width of a count able to hold 0..width
package posit_lzc_pkg;

    localparam logic [1:0] LZC_MODE_LZ  = 2'b00;
    localparam logic [1:0] LZC_MODE_LO  = 2'b01;
    localparam logic [1:0] LZC_MODE_RUN = 2'b10;

    function automatic int lzc_cw(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/lzc_nibble.sv
// lzc_nibble
// Combinational leading-zero count of one 4-bit group.
//   nib_i      : group, MSB first
//   all_zero_o : group is entirely zero
//   cnt2_o     : leading zeros 0..3 (don't care when all_zero_o is set)
module lzc_nibble (
    input  logic [3:0] nib_i,
    output logic       all_zero_o,
    output logic [1:0] cnt2_o
);

    always_comb begin
        all_zero_o = (nib_i == 4'b0000);
        casez (nib_i)
            4'b1???: cnt2_o = 2'd0;
            4'b01??: cnt2_o = 2'd1;
            4'b001?: cnt2_o = 2'd2;
            default: cnt2_o = 2'd3;
        endcase
    end

endmodule

// File: rtl/posit_lzc_pipe.sv
// posit_lzc_pipe
// Two-stage pipelined leading-run counter for the posit decode path.
// Counts leading zeros (LZ), leading ones (LO) or the run of bits equal to
// the MSB (RUN, the posit regime). Mode 2'b11 is decoded as LZ.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake (accept = in_valid & in_ready)
//   in_data, in_mode    : word to scan (MSB first) and scan mode
//   in_tag              : sideband, returned unchanged with the result
//   out_valid/out_ready : output handshake (result = out_valid & out_ready)
//   out_count           : run length 0..WIDTH
//   out_full            : the whole word is the run (out_count == WIDTH)
//   out_tag             : tag of this result
//   out_norm            : in_data << out_count, only with POSIT_LZC_NORM_EN
//
// Handshake: a stage advances when it is empty or the stage after it
// advances; in_ready depends only on out_ready and the valid flops. While
// out_valid is high and out_ready low, every output is held.
//
// Configuration macro: POSIT_LZC_NORM_EN adds the out_norm shifter.
module posit_lzc_pipe
    import posit_lzc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [1:0]             in_mode,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(WIDTH):0] out_count,
    output logic                   out_full,
    output logic [TAG_W-1:0]       out_tag
`ifdef POSIT_LZC_NORM_EN
    ,
    output logic [WIDTH-1:0]       out_norm
`endif
);

    localparam int CW = lzc_cw(WIDTH);
    localparam int NG = WIDTH / 4;

    // Conditioning turns every mode into a leading-zero count.
    logic [WIDTH-1:0] cond_w;
    always_comb begin
        case (in_mode)
            LZC_MODE_LO:  cond_w = ~in_data;
            LZC_MODE_RUN: cond_w = in_data ^ {WIDTH{in_data[WIDTH-1]}};
            default:      cond_w = in_data;
        endcase
    end

    // Group 0 is the most significant nibble.
    logic [NG-1:0]      az_w;
    logic [NG-1:0][1:0] cnt2_w;
    for (genvar g = 0; g < NG; g++) begin : g_nib
        lzc_nibble u_nib (
            .nib_i      (cond_w[WIDTH-1-4*g -: 4]),
            .all_zero_o (az_w[g]),
            .cnt2_o     (cnt2_w[g])
        );
    end

    logic s1_valid_q;
    logic s2_valid_q;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;

    // Stage 1: per-group summaries and tag.
    logic [NG-1:0]      s1_az_q;
    logic [NG-1:0][1:0] s1_cnt2_q;
    logic [TAG_W-1:0]   s1_tag_q;
`ifdef POSIT_LZC_NORM_EN
    // The original word is kept (not the conditioned one): shifting it left
    // by the run length drops the run and leaves the terminator in the MSB.
    logic [WIDTH-1:0]   s1_data_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_az_q    <= '0;
            s1_cnt2_q  <= '0;
            s1_tag_q   <= '0;
`ifdef POSIT_LZC_NORM_EN
            s1_data_q  <= '0;
`endif
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_az_q   <= az_w;
                s1_cnt2_q <= cnt2_w;
                s1_tag_q  <= in_tag;
`ifdef POSIT_LZC_NORM_EN
                s1_data_q <= in_data;
`endif
            end
        end
    end

    // Stage 2 combinational: first non-zero group wins. Scanning from the
    // least significant group upward lets the last hit be the leading one.
    logic [CW-1:0] count_d;
    logic          full_d;
    always_comb begin
        count_d = CW'(WIDTH);
        full_d  = &s1_az_q;
        for (int g = NG - 1; g >= 0; g--) begin
            if (!s1_az_q[g]) begin
                count_d = CW'(g * 4 + int'(s1_cnt2_q[g]));
            end
        end
    end

`ifdef POSIT_LZC_NORM_EN
    logic [WIDTH-1:0] norm_d;
    logic [WIDTH-1:0] out_norm_q;
    // A full run shifts by WIDTH, which zero-fills the whole word.
    assign norm_d   = s1_data_q << count_d;
    assign out_norm = out_norm_q;
`endif

    logic [CW-1:0]    out_count_q;
    logic             out_full_q;
    logic [TAG_W-1:0] out_tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q  <= 1'b0;
            out_count_q <= '0;
            out_full_q  <= 1'b0;
            out_tag_q   <= '0;
`ifdef POSIT_LZC_NORM_EN
            out_norm_q  <= '0;
`endif
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_count_q <= count_d;
                out_full_q  <= full_d;
                out_tag_q   <= s1_tag_q;
`ifdef POSIT_LZC_NORM_EN
                out_norm_q  <= norm_d;
`endif
            end
        end
    end

    assign out_count = out_count_q;
    assign out_full  = out_full_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_posit_lzc_pipe.sv
// tb_posit_lzc_pipe
// Scoreboard bench for posit_lzc_pipe (WIDTH=16, TAG_W=4). Inputs are driven
// 1 time unit after the rising edge; all sampling happens on the falling edge.
// Builds with or without POSIT_LZC_NORM_EN.
module tb_posit_lzc_pipe;

    localparam int WIDTH = 16;
    localparam int TAG_W = 4;
    localparam int CW    = 5;

    typedef struct packed {
        logic [CW-1:0]    count;
        logic             full;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] norm;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
    logic             out_full;
    logic [TAG_W-1:0] out_tag;
    logic [WIDTH-1:0] norm_obs;
`ifdef POSIT_LZC_NORM_EN
    logic [WIDTH-1:0] out_norm;
    assign norm_obs = out_norm;
`else
    assign norm_obs = '0;
`endif

    posit_lzc_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_full  (out_full),
        .out_tag   (out_tag)
`ifdef POSIT_LZC_NORM_EN
        ,
        .out_norm  (out_norm)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    // Walk the word from the MSB and count bits equal to the run value.
    function automatic exp_t model(input logic [WIDTH-1:0] d, input logic [1:0] m,
                                   input logic [TAG_W-1:0] t);
        exp_t r;
        logic target;
        logic done;
        int   n;
        case (m)
            2'b01:   target = 1'b1;
            2'b10:   target = d[WIDTH-1];
            default: target = 1'b0;
        endcase
        n = 0;
        done = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!done && d[i] == target) n++;
            else done = 1'b1;
        end
        r.count = CW'(n);
        r.full  = (n == WIDTH);
        r.tag   = t;
        r.norm  = (n >= WIDTH) ? '0 : (d << n);
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           cyc_q[$];
    logic         strict_lat = 1'b1;

    task automatic push_exp(input logic [WIDTH-1:0] d, input logic [1:0] m,
                            input logic [TAG_W-1:0] t, input int exp_cnt);
        exp_t e;
        e = model(d, m, t);
        if (exp_cnt >= 0) begin
            e.count = CW'(exp_cnt);
            e.full  = (exp_cnt == WIDTH);
        end
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
    endtask

    logic             stall_prev = 1'b0;
    logic [CW-1:0]    prev_count;
    logic             prev_full;
    logic [TAG_W-1:0] prev_tag;
    logic [WIDTH-1:0] prev_norm;

    always @(negedge clk) begin
        exp_t e;
        int   c;
        if (rst) begin
            exp_q.delete();
            cyc_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_count", out_count, prev_count);
                check("hold_full", out_full, prev_full);
                check("hold_tag", out_tag, prev_tag);
`ifdef POSIT_LZC_NORM_EN
                check("hold_norm", norm_obs, prev_norm);
`endif
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    check("count", out_count, e.count);
                    check("full", out_full, e.full);
                    check("tag", out_tag, e.tag);
`ifdef POSIT_LZC_NORM_EN
                    check("norm", norm_obs, e.norm);
`endif
                    if (strict_lat) check("latency", cyc - c, 2);
                    else check("latency_min", (cyc - c) >= 2, 1);
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_count = out_count;
            prev_full  = out_full;
            prev_tag   = out_tag;
            prev_norm  = norm_obs;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [WIDTH-1:0] d, input logic [1:0] m,
                        input logic [TAG_W-1:0] t, input int exp_cnt);
        bit acc;
        int k;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_tag   = t;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 200) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                push_exp(d, m, t, exp_cnt);
                acc = 1'b1;
            end
            k++;
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(posedge clk); #2;
            k++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    logic rand_ready_en = 1'b0;
    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- stimulus ----------------
    logic [WIDTH-1:0] bp_d [4];
    logic [1:0]       bp_m [4];
    int               idx;
    int               t;
    logic [WIDTH-1:0] rd;
    int               sh;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'b00;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_count", out_count, 0);
        check("rst_out_full", out_full, 0);
        check("rst_out_tag", out_tag, 0);

        // Directed vectors, back to back with no stall.
        send(16'h0010, 2'b00, 4'd3, 11);
        send(16'h0000, 2'b00, 4'd1, 16);
        send(16'hF0FF, 2'b01, 4'd2, 4);
        send(16'hFFFF, 2'b01, 4'd4, 16);
        send(16'hFFE0, 2'b10, 4'd5, 11);
        send(16'h0003, 2'b10, 4'd6, 14);
        send(16'h0100, 2'b11, 4'd7, 7);
        send(16'h0013, 2'b10, 4'd8, 11);
        send(16'h8000, 2'b00, 4'd9, 0);
        send(16'h7FFF, 2'b10, 4'd10, 1);
        idle();
        drain();

        // Backpressure: four words offered while out_ready is low for 4 cycles.
        strict_lat = 1'b0;
        bp_d[0] = 16'h0400; bp_m[0] = 2'b00;
        bp_d[1] = 16'hFF0F; bp_m[1] = 2'b01;
        bp_d[2] = 16'hC000; bp_m[2] = 2'b10;
        bp_d[3] = 16'h0007; bp_m[3] = 2'b10;
        @(posedge clk); #1;
        out_ready = 1'b0;
        idx = 0;
        t = 0;
        in_valid = 1'b1;
        in_data  = bp_d[0];
        in_mode  = bp_m[0];
        in_tag   = 4'hA;
        while (idx < 4 && t < 100) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(bp_d[idx], bp_m[idx], TAG_W'(4'hA + idx), -1);
                idx++;
            end
            if (t == 3) begin
                check("bp_accepts_before_stall", idx, 2);
                check("bp_in_ready_low", in_ready, 0);
            end
            @(posedge clk); #1;
            if (t == 3) out_ready = 1'b1;
            if (idx < 4) begin
                in_data = bp_d[idx];
                in_mode = bp_m[idx];
                in_tag  = TAG_W'(4'hA + idx);
            end else begin
                in_valid = 1'b0;
            end
            t++;
        end
        check("bp_all_accepted", idx, 4);
        in_valid = 1'b0;
        drain();

        // Reset during a stall with two words in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'h00F0, 2'b00, 4'd1, -1);
        send(16'h0F00, 2'b01, 4'd2, -1);
        idle();
        @(negedge clk);
        check("pre_rst_out_valid", out_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_count", out_count, 0);
        check("midrst_out_full", out_full, 0);
        check("midrst_out_tag", out_tag, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        strict_lat = 1'b1;
        send(16'h0020, 2'b00, 4'd12, 10);
        idle();
        drain();
        repeat (4) @(posedge clk);

        // Random traffic against random backpressure.
        strict_lat = 1'b0;
        rand_ready_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rd = WIDTH'($urandom);
            sh = $urandom_range(0, 18);
            if (sh <= 16) rd = rd >> sh;
            if ($urandom_range(0, 1) == 1) rd = ~rd;
            send(rd, 2'($urandom_range(0, 3)), TAG_W'($urandom), -1);
            if ($urandom_range(0, 7) == 0) idle();
        end
        idle();
        rand_ready_en = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
